// File: rtl/crc8_arb_pkg.sv
// Shared types and constants for the CRC8816 round-robin arbiter.
// Holds the FSM state encoding, pointer/counter widths and the round-robin successor helper.
package crc8_arb_pkg;

    localparam int CRC8_ARB_MAX_REQ = 8;
    localparam int CRC8_ARB_PTR_W   = 3;
    localparam int CRC8_ARB_TO_W    = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CLEAR     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESULT    = 3'd4
    } crc8_arb_state_t;

    function automatic logic [CRC8_ARB_PTR_W-1:0] crc8_arb_next_ptr(input int idx, input int num_req);
        return ((idx + 1) >= num_req) ? {CRC8_ARB_PTR_W{1'b0}} : CRC8_ARB_PTR_W'(idx + 1);
    endfunction

endpackage

// File: rtl/crc8_arbiter_checker.sv
// Bound property checker for crc8_arbiter: grant is one-hot, completion goes to the owner,
// and done/abort never coincide.
module crc8_arbiter_checker #(
    parameter int NUM_REQ = 2
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_REQ-1:0] gnt,
    input logic [NUM_REQ-1:0] done,
    input logic [NUM_REQ-1:0] abort
);

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(gnt));
    a_done_owner:  assert property (@(posedge clk) disable iff (reset) ((done & ~gnt) == '0));
    a_done_abort:  assert property (@(posedge clk) disable iff (reset) !((|done) && (|abort)));

endmodule

bind crc8_arbiter crc8_arbiter_checker #(.NUM_REQ(NUM_REQ)) u_checker (
    .clk   (clk),
    .reset (reset),
    .gnt   (o_gnt),
    .done  (o_done),
    .abort (o_abort)
);

// File: rtl/crc8_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces a one-hot winner and a valid flag; no state.
module crc8_rr_picker
    import crc8_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [CRC8_ARB_PTR_W-1:0] ptr,
    output logic [NUM_REQ-1:0]        winner,
    output logic                      valid
);

    // Pass 1 scans indices at or above ptr, pass 2 wraps to the low indices.
    always_comb begin
        logic hit_s;
        hit_s  = 1'b0;
        winner = '0;
        valid  = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            hit_s     = req[j] & ~valid & (j >= int'(ptr));
            winner[j] = hit_s;
            valid     = valid | hit_s;
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            hit_s     = req[j] & ~valid;
            winner[j] = winner[j] | hit_s;
            valid     = valid | hit_s;
        end
    end

endmodule

// File: rtl/crc8_arbiter.sv
// Round-robin sequencer sharing one CRC8816 engine between NUM_REQ byte-stream requesters.
// Optional idle-timeout abort is built when CRC8_ARB_TIMEOUT_EN is defined.
module crc8_arbiter
    import crc8_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   i_req,
    output logic [NUM_REQ-1:0]   o_gnt,
    input  logic [NUM_REQ-1:0]   i_valid,
    input  logic [NUM_REQ-1:0]   i_last,
    input  logic [NUM_REQ*8-1:0] i_data,
    output logic                 o_crc_clr,
    output logic                 o_crc_valid,
    output logic                 o_crc_last,
    output logic [7:0]           o_crc_data,
    input  logic                 i_crc_done,
    input  logic                 i_crc_match,
    output logic [NUM_REQ-1:0]   o_done,
    output logic                 o_match,
    output logic [NUM_REQ-1:0]   o_abort
);

    crc8_arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]        gnt_q, gnt_d, done_q, done_d, abort_q, abort_d;
    logic                      crc_clr_q, crc_clr_d, crc_valid_q, crc_valid_d;
    logic                      crc_last_q, crc_last_d, match_q, match_d;
    logic [7:0]                crc_data_q, crc_data_d;
    logic [CRC8_ARB_PTR_W-1:0] rr_ptr_q, rr_ptr_d, next_ptr_s;
    logic [NUM_REQ-1:0]        pick_gnt_s;
    logic                      pick_valid_s, own_valid_s, own_last_s, to_fire_s;
    logic [7:0]                own_data_s;

    crc8_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (i_req),
        .ptr    (rr_ptr_q),
        .winner (pick_gnt_s),
        .valid  (pick_valid_s)
    );

    // Select the owner's stream through the one-hot grant and precompute its successor.
    always_comb begin
        own_valid_s = |(i_valid & gnt_q);
        own_last_s  = |(i_last & gnt_q);
        own_data_s  = 8'h00;
        next_ptr_s  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            own_data_s = own_data_s | (i_data[j*8 +: 8] & {8{gnt_q[j]}});
            next_ptr_s = next_ptr_s | (gnt_q[j] ? crc8_arb_next_ptr(j, NUM_REQ) : '0);
        end
    end

`ifdef CRC8_ARB_TIMEOUT_EN
    logic [CRC8_ARB_TO_W-1:0] to_cnt_q, to_cnt_d;
    logic                     to_idle_s;

    // Idle-cycle counter: cleared on entry to STREAM/WAIT_DONE, counts cycles without progress.
    always_comb begin
        to_idle_s = ((state_q == ST_STREAM) && !own_valid_s) ||
                    ((state_q == ST_WAIT_DONE) && !i_crc_done);
        to_fire_s = to_idle_s && (to_cnt_q == CRC8_ARB_TO_W'(TIMEOUT_CYCLES - 1));
        if ((state_q == ST_CLEAR) || ((state_q == ST_STREAM) && own_valid_s && own_last_s)) begin
            to_cnt_d = '0;
        end else if (to_idle_s) begin
            to_cnt_d = to_cnt_q + 16'd1;
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    logic unused_cfg_s;
    assign to_fire_s    = 1'b0;
    assign unused_cfg_s = ^32'(TIMEOUT_CYCLES);
`endif

    // Sequencer next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = '0;
        abort_d     = '0;
        crc_clr_d   = 1'b0;
        crc_valid_d = 1'b0;
        crc_last_d  = 1'b0;
        crc_data_d  = crc_data_q;
        match_d     = match_q;
        rr_ptr_d    = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    gnt_d     = pick_gnt_s;
                    crc_clr_d = 1'b1;
                    state_d   = ST_CLEAR;
                end else begin
                    gnt_d = '0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                crc_valid_d = own_valid_s;
                crc_last_d  = own_last_s;
                crc_data_d  = own_data_s;
                if (own_valid_s && own_last_s) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_fire_s) begin
                    abort_d   = gnt_q;
                    crc_clr_d = 1'b1;
                    rr_ptr_d  = next_ptr_s;
                    gnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_WAIT_DONE: begin
                if (i_crc_done) begin
                    done_d  = gnt_q;
                    match_d = i_crc_match;
                    state_d = ST_RESULT;
                end else if (to_fire_s) begin
                    abort_d   = gnt_q;
                    crc_clr_d = 1'b1;
                    rr_ptr_d  = next_ptr_s;
                    gnt_d     = '0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_RESULT: begin
                rr_ptr_d = next_ptr_s;
                gnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= '0;
            done_q      <= '0;
            abort_q     <= '0;
            crc_clr_q   <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_last_q  <= 1'b0;
            crc_data_q  <= 8'h00;
            match_q     <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            crc_clr_q   <= crc_clr_d;
            crc_valid_q <= crc_valid_d;
            crc_last_q  <= crc_last_d;
            crc_data_q  <= crc_data_d;
            match_q     <= match_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign o_gnt       = gnt_q;
    assign o_done      = done_q;
    assign o_abort     = abort_q;
    assign o_crc_clr   = crc_clr_q;
    assign o_crc_valid = crc_valid_q;
    assign o_crc_last  = crc_last_q;
    assign o_crc_data  = crc_data_q;
    assign o_match     = match_q;

endmodule

// File: tb/tb_crc8_arbiter.sv
// Directed self-checking bench for crc8_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=10).
// The timeout scenario runs only when CRC8_ARB_TIMEOUT_EN is defined.
module tb_crc8_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  i_req, o_gnt, i_valid, i_last, o_done, o_abort;
    logic [15:0] i_data;
    logic        o_crc_clr, o_crc_valid, o_crc_last, i_crc_done, i_crc_match, o_match;
    logic [7:0]  o_crc_data;
    int          n_checks = 0;
    int          n_fail   = 0;

    crc8_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .i_req(i_req), .o_gnt(o_gnt), .i_valid(i_valid),
        .i_last(i_last), .i_data(i_data), .o_crc_clr(o_crc_clr), .o_crc_valid(o_crc_valid),
        .o_crc_last(o_crc_last), .o_crc_data(o_crc_data), .i_crc_done(i_crc_done),
        .i_crc_match(i_crc_match), .o_done(o_done), .o_match(o_match), .o_abort(o_abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1; i_req = 2'b00; i_valid = 2'b00; i_last = 2'b00; i_data = 16'h0000;
        i_crc_done = 1'b0; i_crc_match = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pulse_reset();
        tick();
        n_checks++; if (o_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", o_gnt); end
        n_checks++; if (o_crc_clr !== 1'b0 || o_crc_valid !== 1'b0 || o_crc_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_crc_ctl: got clr=%b valid=%b last=%b want 0", o_crc_clr, o_crc_valid, o_crc_last); end
        n_checks++; if (o_crc_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_crc_data); end
        n_checks++; if (o_done !== 2'b00 || o_abort !== 2'b00 || o_match !== 1'b0) begin
            n_fail++; $display("FAIL reset_result: got done=%b abort=%b match=%b want 0", o_done, o_abort, o_match); end
    endtask

    task automatic test_single_packet();
        logic [7:0] b;
        i_req = 2'b01;
        tick();
        n_checks++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", o_gnt); end
        n_checks++; if (o_crc_clr !== 1'b1) begin n_fail++; $display("FAIL single_clr: got %b want 1", o_crc_clr); end
        tick();
        n_checks++; if (o_crc_clr !== 1'b0) begin n_fail++; $display("FAIL single_clr_len: got %b want 0", o_crc_clr); end
        for (int k = 0; k < 4; k++) begin
            b = 8'h01 + 8'(k);
            i_valid = 2'b01; i_data = {8'h00, b}; i_last = (k == 3) ? 2'b01 : 2'b00;
            tick();
            n_checks++; if (o_crc_valid !== 1'b1 || o_crc_data !== b || o_crc_last !== (k == 3)) begin
                n_fail++; $display("FAIL single_byte%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", k, o_crc_valid, o_crc_data, o_crc_last, b, (k == 3)); end
        end
        i_valid = 2'b00; i_last = 2'b00; i_req = 2'b00;
        tick();
        n_checks++; if (o_crc_valid !== 1'b0 || o_done !== 2'b00) begin
            n_fail++; $display("FAIL single_wait: got valid=%b done=%b want 0/00", o_crc_valid, o_done); end
        i_crc_done = 1'b1; i_crc_match = 1'b1;
        tick();
        n_checks++; if (o_done !== 2'b01 || o_match !== 1'b1) begin
            n_fail++; $display("FAIL single_done: got done=%b match=%b want 01/1", o_done, o_match); end
        i_crc_done = 1'b0; i_crc_match = 1'b0;
        tick();
        n_checks++; if (o_done !== 2'b00 || o_gnt !== 2'b00) begin
            n_fail++; $display("FAIL single_release: got done=%b gnt=%b want 00/00", o_done, o_gnt); end
    endtask

    task automatic test_simultaneous();
        int own [3] = '{0, 1, 0};
        logic [1:0] exp_g;
        pulse_reset();
        i_req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            exp_g = (own[i] == 0) ? 2'b01 : 2'b10;
            tick();
            n_checks++; if (o_gnt !== exp_g) begin n_fail++; $display("FAIL simul_gnt%0d: got %b want %b", i, o_gnt, exp_g); end
            tick();
            i_valid = exp_g; i_last = exp_g;
            i_data = (own[i] == 0) ? 16'h0030 : 16'h3000;
            tick();
            n_checks++; if (o_crc_data !== 8'h30 || o_crc_last !== 1'b1) begin
                n_fail++; $display("FAIL simul_data%0d: got %h/%b want 30/1", i, o_crc_data, o_crc_last); end
            i_valid = 2'b00; i_last = 2'b00; i_crc_done = 1'b1; i_crc_match = 1'b1;
            tick();
            n_checks++; if (o_done !== exp_g) begin n_fail++; $display("FAIL simul_done%0d: got %b want %b", i, o_done, exp_g); end
            i_crc_done = 1'b0;
            if (i == 2) i_req = 2'b00;
            tick();
        end
        tick();
        n_checks++; if (o_gnt !== 2'b00) begin n_fail++; $display("FAIL simul_idle: got %b want 00", o_gnt); end
    endtask

    task automatic test_crosstalk();
        logic [7:0] b;
        pulse_reset();
        i_req = 2'b01;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            b = 8'h11 + 8'(k);
            i_valid = 2'b11; i_data = {8'hAA, b}; i_last = (k == 2) ? 2'b11 : 2'b10;
            tick();
            n_checks++; if (o_crc_data !== b) begin n_fail++; $display("FAIL xtalk_byte%0d: got %h want %h", k, o_crc_data, b); end
        end
        i_data = 16'hAA55; i_last = 2'b00;
        tick();
        n_checks++; if (o_crc_valid !== 1'b0 || o_crc_data === 8'h55 || o_crc_data === 8'hAA) begin
            n_fail++; $display("FAIL xtalk_after_last: got valid=%b data=%h want 0/13", o_crc_valid, o_crc_data); end
        i_valid = 2'b00; i_crc_done = 1'b1; i_crc_match = 1'b1;
        tick();
        n_checks++; if (o_done !== 2'b01) begin n_fail++; $display("FAIL xtalk_done: got %b want 01", o_done); end
        i_crc_done = 1'b0; i_req = 2'b00;
        tick();
    endtask

    task automatic test_mismatch();
        i_crc_done = 1'b1; i_crc_match = 1'b0;
        tick();
        n_checks++; if (o_done !== 2'b00 || o_match !== 1'b1) begin
            n_fail++; $display("FAIL stray_done: got done=%b match=%b want 00/1", o_done, o_match); end
        i_crc_done = 1'b0; i_req = 2'b01;
        tick();
        n_checks++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL mis_gnt_wrap: got %b want 01", o_gnt); end
        tick();
        i_valid = 2'b01; i_data = 16'h0021; i_req = 2'b00;
        tick();
        i_data = 16'h0022; i_last = 2'b01;
        tick();
        n_checks++; if (o_gnt !== 2'b01 || o_crc_last !== 1'b1 || o_crc_data !== 8'h22) begin
            n_fail++; $display("FAIL mis_hold: got gnt=%b last=%b data=%h want 01/1/22", o_gnt, o_crc_last, o_crc_data); end
        i_valid = 2'b00; i_last = 2'b00;
        tick();
        tick();
        n_checks++; if (o_done !== 2'b00 || o_gnt !== 2'b01) begin
            n_fail++; $display("FAIL mis_wait: got done=%b gnt=%b want 00/01", o_done, o_gnt); end
        i_crc_done = 1'b1; i_crc_match = 1'b0;
        tick();
        n_checks++; if (o_done !== 2'b01 || o_match !== 1'b0) begin
            n_fail++; $display("FAIL mis_done: got done=%b match=%b want 01/0", o_done, o_match); end
        i_crc_done = 1'b0;
        tick();
        tick();
        n_checks++; if (o_gnt !== 2'b00) begin n_fail++; $display("FAIL mis_release: got %b want 00", o_gnt); end
    endtask

    task automatic test_reset_midstream();
        i_req = 2'b11;
        tick();
        n_checks++; if (o_gnt !== 2'b10) begin n_fail++; $display("FAIL rst_pre_gnt: got %b want 10", o_gnt); end
        tick();
        i_valid = 2'b10; i_data = 16'hB100;
        tick();
        i_data = 16'hB200;
        tick();
        n_checks++; if (o_crc_data !== 8'hB2) begin n_fail++; $display("FAIL rst_pre_data: got %h want b2", o_crc_data); end
        reset = 1'b1;
        tick();
        n_checks++; if (o_gnt !== 2'b00 || o_crc_valid !== 1'b0 || o_crc_data !== 8'h00 || o_crc_clr !== 1'b0
                        || o_done !== 2'b00 || o_abort !== 2'b00 || o_match !== 1'b0 || o_crc_last !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_zero: got gnt=%b v=%b d=%h clr=%b done=%b abort=%b want all 0",
                               o_gnt, o_crc_valid, o_crc_data, o_crc_clr, o_done, o_abort); end
        reset = 1'b0; i_valid = 2'b00; i_data = 16'h0000;
        tick();
        n_checks++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL rst_post_gnt: got %b want 01", o_gnt); end
        i_req = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (o_done !== 2'b00 || o_abort !== 2'b00) begin
                n_fail++; $display("FAIL rst_no_pulse%0d: got done=%b abort=%b want 00/00", k, o_done, o_abort); end
        end
    endtask

`ifdef CRC8_ARB_TIMEOUT_EN
    task automatic test_timeout();
        pulse_reset();
        i_req = 2'b11;
        tick();
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k < 10) begin
                n_checks++; if (o_abort !== 2'b00 || o_gnt !== 2'b01) begin
                    n_fail++; $display("FAIL to_early%0d: got abort=%b gnt=%b want 00/01", k, o_abort, o_gnt); end
            end else begin
                n_checks++; if (o_abort !== 2'b01 || o_crc_clr !== 1'b1 || o_gnt !== 2'b00) begin
                    n_fail++; $display("FAIL to_fire: got abort=%b clr=%b gnt=%b want 01/1/00", o_abort, o_crc_clr, o_gnt); end
            end
        end
        tick();
        n_checks++; if (o_gnt !== 2'b10 || o_abort !== 2'b00 || o_done !== 2'b00) begin
            n_fail++; $display("FAIL to_next: got gnt=%b abort=%b done=%b want 10/00/00", o_gnt, o_abort, o_done); end
        pulse_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_packet();
        test_simultaneous();
        test_crosstalk();
        test_mismatch();
        test_reset_midstream();
`ifdef CRC8_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
